clkdiv_monitor: RTL and testbench

Checks a divided clock against an expected waveform, sampling it in the source clock domain. It sits beside the clock divider and samples `clk_div_in` through a 2-flop synchronizer. It measures the high-phase and low-phase lengths in `clk` cycles, declares lock after a run of consecutive correct periods, and flags bad periods and a stuck input. Its outputs feed status registers and bring-up logic, and the block doubles as a self-checking companion for the divider's test bench.

---
 rtl/clkdiv_monitor.sv | 165 ++++++++++++++++
 tb/tb_clkdiv_monitor.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_monitor.sv
// Divided-clock checker: synchronizes clk_div_in, measures high/low phase
// lengths in clk cycles, tracks lock, and flags bad periods and stuck input.
module clkdiv_monitor #(
   parameter int unsigned EXP_HIGH = 1,
   parameter int unsigned EXP_LOW  = 1,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clk_div_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             err,
   output logic             stuck,
   output logic             meas_valid,
   output logic [CNT_W-1:0] high_len,
   output logic [CNT_W-1:0] low_len,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
   localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LOW);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [7:0]       LOCK_N  = 8'(LOCK_CNT);

   logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
   logic [CNT_W-1:0] high_len_q, high_len_d;
   logic [CNT_W-1:0] low_len_q, low_len_d;
   state_t           state_q, state_d;
   logic [7:0]       good_cnt_q, good_cnt_d;
   logic             fall_seen_q, fall_seen_d;
   logic             err_q, err_d;
   logic             stuck_q, stuck_d;
   logic             meas_valid_q, meas_valid_d;
   logic             locked_q, locked_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic rise, fall, any_edge, judge, good;

   always_comb begin
      s1_d = clk_div_in;
      s2_d = s1_q;
      s3_d = s2_q;
      rise = s2_q & ~s3_q;
      fall = ~s2_q & s3_q;
      any_edge = rise | fall;

      run_cnt_d = run_cnt_q;
      if (any_edge) begin
         run_cnt_d = CNT_W'(1);
      end else if (run_cnt_q != CNT_MAX) begin
         run_cnt_d = run_cnt_q + CNT_W'(1);
      end

      hi_tmp_d   = fall ? run_cnt_q : hi_tmp_q;
      high_len_d = rise ? hi_tmp_q : high_len_q;
      low_len_d  = rise ? run_cnt_q : low_len_q;

      // a rise only closes a full period once a fall was seen in tracking
      judge = rise && fall_seen_q && (state_q != IDLE);
      good  = (hi_tmp_q == EXP_H) && (run_cnt_q == EXP_L);

      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      fall_seen_d  = fall_seen_q | (fall && (state_q != IDLE));
      err_d        = 1'b0;
      stuck_d      = 1'b0;
      meas_valid_d = judge;

      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d     = TRACK;
               good_cnt_d  = '0;
               fall_seen_d = 1'b0;
            end
         end
         TRACK: begin
            if (judge && good) begin
               good_cnt_d = good_cnt_q + 8'd1;
               if (good_cnt_q + 8'd1 == LOCK_N) begin
                  state_d = LOCKED;
               end
            end else if (judge) begin
               good_cnt_d = '0;
               err_d      = 1'b1;
            end
         end
         LOCKED: begin
            if (judge && !good) begin
               good_cnt_d = '0;
               err_d      = 1'b1;
               state_d    = TRACK;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && !any_edge && (run_cnt_q == TMO)) begin
         stuck_d = 1'b1;
         state_d = IDLE;
      end

      locked_d = (state_d == LOCKED);

      err_cnt_d = err_cnt_q;
      if (clr_err) begin
         err_cnt_d = '0;
      end else if ((err_d | stuck_d) && (err_cnt_q != 8'hff)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         run_cnt_q    <= '0;
         hi_tmp_q     <= '0;
         high_len_q   <= '0;
         low_len_q    <= '0;
         state_q      <= IDLE;
         good_cnt_q   <= '0;
         fall_seen_q  <= 1'b0;
         err_q        <= 1'b0;
         stuck_q      <= 1'b0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         run_cnt_q    <= run_cnt_d;
         hi_tmp_q     <= hi_tmp_d;
         high_len_q   <= high_len_d;
         low_len_q    <= low_len_d;
         state_q      <= state_d;
         good_cnt_q   <= good_cnt_d;
         fall_seen_q  <= fall_seen_d;
         err_q        <= err_d;
         stuck_q      <= stuck_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign locked     = locked_q;
   assign err        = err_q;
   assign stuck      = stuck_q;
   assign meas_valid = meas_valid_q;
   assign high_len   = high_len_q;
   assign low_len    = low_len_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Bench for clkdiv_monitor: default divide-by-2 instance and a
// divide-by-4 instance, with a queue of expected phase measurements.
module tb_clkdiv_monitor;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] l;
   } meas_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       clr_err = 1'b0;
   logic       din [2];

   logic       locked0, err0, stuck0, meas0;
   logic [7:0] hl0, ll0, ec0;
   logic       locked1, err1, stuck1, meas1;
   logic [7:0] hl1, ll1, ec1;

   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    t_fall = 0;
   int    stuck_cyc = 0;
   int    errs0 = 0, errs1 = 0, stucks0 = 0, lock_hits1 = 0;
   bit    watch1 = 1'b0;
   meas_t q0[$];
   meas_t q1[$];
   int    pend_h [2];
   int    pend_l [2];
   bit    pend_v [2];

   clkdiv_monitor u_dut0 (
      .clk(clk), .rstn(rstn), .clk_div_in(din[0]), .clr_err(clr_err),
      .locked(locked0), .err(err0), .stuck(stuck0), .meas_valid(meas0),
      .high_len(hl0), .low_len(ll0), .err_cnt(ec0)
   );

   clkdiv_monitor #(.EXP_HIGH(2), .EXP_LOW(2)) u_dut1 (
      .clk(clk), .rstn(rstn), .clk_div_in(din[1]), .clr_err(clr_err),
      .locked(locked1), .err(err1), .stuck(stuck1), .meas_valid(meas1),
      .high_len(hl1), .low_len(ll1), .err_cnt(ec1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time expired, required finish");
      $fatal(1);
   end

   // scoreboard pops on every measurement pulse
   initial begin
      meas_t m;
      forever begin
         @(negedge clk);
         if (err0) errs0++;
         if (err1) errs1++;
         if (stuck0) begin
            stucks0++;
            stuck_cyc = cyc;
         end
         if (watch1 && locked1) lock_hits1++;
         if (meas0) begin
            n_checks++;
            if (q0.size() == 0) begin
               n_fail++;
               $display("FAIL meas0_unexpected: got %0d/%0d, none queued", hl0, ll0);
            end else begin
               m = q0.pop_front();
               if (hl0 !== m.h || ll0 !== m.l) begin
                  n_fail++;
                  $display("FAIL meas0: got %0d/%0d, want %0d/%0d", hl0, ll0, m.h, m.l);
               end
            end
         end
         if (meas1) begin
            n_checks++;
            if (q1.size() == 0) begin
               n_fail++;
               $display("FAIL meas1_unexpected: got %0d/%0d, none queued", hl1, ll1);
            end else begin
               m = q1.pop_front();
               if (hl1 !== m.h || ll1 !== m.l) begin
                  n_fail++;
                  $display("FAIL meas1: got %0d/%0d, want %0d/%0d", hl1, ll1, m.h, m.l);
               end
            end
         end
      end
   end

   task automatic drive_phase(input int sel, input logic lvl, input int n);
      din[sel] = lvl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // the rise starting this period closes the previous one
   task automatic drive_period(input int sel, input int h, input int l);
      meas_t m;
      if (pend_v[sel]) begin
         m.h = 8'(pend_h[sel]);
         m.l = 8'(pend_l[sel]);
         if (sel == 0) q0.push_back(m);
         else q1.push_back(m);
      end
      drive_phase(sel, 1'b1, h);
      if (sel == 0) t_fall = cyc;
      drive_phase(sel, 1'b0, l);
      pend_h[sel] = h;
      pend_l[sel] = l;
      pend_v[sel] = 1'b1;
   endtask

   task automatic test_reset();
      din[0] = 1'b0;
      din[1] = 1'b0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({locked0, err0, stuck0, meas0} !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_flags0: got %b, want 0000", {locked0, err0, stuck0, meas0});
      end
      n_checks++;
      if ({hl0, ll0, ec0} !== 24'h0) begin
         n_fail++;
         $display("FAIL rst_vals0: got %h, want 000000", {hl0, ll0, ec0});
      end
      n_checks++;
      if ({locked1, err1, stuck1, meas1, hl1, ll1, ec1} !== 28'h0) begin
         n_fail++;
         $display("FAIL rst_dut1: got %h, want 0", {locked1, err1, stuck1, meas1, hl1, ll1, ec1});
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_div2_lock(input string tag);
      pend_v[0] = 1'b0;
      repeat (5) drive_period(0, 1, 1);
      n_checks++;
      if (locked0 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_early_lock: got %b, want 0", tag, locked0);
      end
      drive_period(0, 1, 1);
      n_checks++;
      if (locked0 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_lock: got %b, want 1", tag, locked0);
      end
      n_checks++;
      if (hl0 !== 8'd1 || ll0 !== 8'd1) begin
         n_fail++;
         $display("FAIL %s_len: got %0d/%0d, want 1/1", tag, hl0, ll0);
      end
   endtask

   task automatic test_stretch();
      int e0;
      e0 = errs0;
      drive_period(0, 3, 1);
      drive_period(0, 1, 1);
      drive_period(0, 1, 1);
      n_checks++;
      if (locked0 !== 1'b0) begin
         n_fail++;
         $display("FAIL stretch_unlock: got %b, want 0", locked0);
      end
      repeat (3) drive_period(0, 1, 1);
      n_checks++;
      if (locked0 !== 1'b0) begin
         n_fail++;
         $display("FAIL stretch_early_relock: got %b, want 0", locked0);
      end
      drive_period(0, 1, 1);
      n_checks++;
      if (locked0 !== 1'b1) begin
         n_fail++;
         $display("FAIL stretch_relock: got %b, want 1", locked0);
      end
      n_checks++;
      if (errs0 - e0 !== 1) begin
         n_fail++;
         $display("FAIL stretch_err_pulses: got %0d, want 1", errs0 - e0);
      end
      n_checks++;
      if (ec0 !== 8'd1) begin
         n_fail++;
         $display("FAIL stretch_err_cnt: got %0d, want 1", ec0);
      end
   endtask

   task automatic test_clear();
      clr_err = 1'b1;
      drive_period(0, 1, 1);
      clr_err = 1'b0;
      n_checks++;
      if (ec0 !== 8'd0) begin
         n_fail++;
         $display("FAIL clear: got %0d, want 0", ec0);
      end
   endtask

   task automatic test_stuck();
      int s0;
      s0 = stucks0;
      drive_period(0, 1, 20);
      pend_v[0] = 1'b0;
      n_checks++;
      if (stucks0 - s0 !== 1) begin
         n_fail++;
         $display("FAIL stuck_pulses: got %0d, want 1", stucks0 - s0);
      end
      n_checks++;
      if (stuck_cyc - t_fall !== 19) begin
         n_fail++;
         $display("FAIL stuck_time: got %0d, want 19", stuck_cyc - t_fall);
      end
      n_checks++;
      if (locked0 !== 1'b0 || ec0 !== 8'd1) begin
         n_fail++;
         $display("FAIL stuck_state: got lock=%b cnt=%0d, want 0/1", locked0, ec0);
      end
      drive_phase(0, 1'b0, 10);
      n_checks++;
      if (stucks0 - s0 !== 1) begin
         n_fail++;
         $display("FAIL stuck_once: got %0d, want 1", stucks0 - s0);
      end
      test_div2_lock("stuck_relock");
   endtask

   task automatic test_reset_mid_lock();
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (q0.size() !== 0) begin
         n_fail++;
         $display("FAIL pre_reset_queue: got %0d, want 0", q0.size());
      end
      n_checks++;
      if (ec0 !== 8'd1 || locked0 !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got cnt=%0d lock=%b, want 1/1", ec0, locked0);
      end
      #1 rstn = 1'b0;
      #1;
      n_checks++;
      if ({locked0, hl0, ll0, ec0} !== 25'h0) begin
         n_fail++;
         $display("FAIL async_reset: got %h, want 0", {locked0, hl0, ll0, ec0});
      end
      pend_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      test_div2_lock("reset_relock");
   endtask

   task automatic test_clr_coincident();
      meas_t m;
      repeat (4) drive_period(0, 3, 1);
      n_checks++;
      if (ec0 !== 8'd3) begin
         n_fail++;
         $display("FAIL pre_clr_cnt: got %0d, want 3", ec0);
      end
      m.h = 8'(pend_h[0]);
      m.l = 8'(pend_l[0]);
      q0.push_back(m);
      din[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (err0 !== 1'b1 || ec0 !== 8'd0) begin
         n_fail++;
         $display("FAIL clr_vs_err: got err=%b cnt=%0d, want 1/0", err0, ec0);
      end
      clr_err = 1'b0;
      drive_phase(0, 1'b0, 1);
      pend_h[0] = 3;
      pend_l[0] = 1;
      pend_v[0] = 1'b1;
   endtask

   task automatic test_saturate();
      repeat (301) drive_period(0, 3, 1);
      n_checks++;
      if (ec0 !== 8'd255) begin
         n_fail++;
         $display("FAIL saturate: got %0d, want 255", ec0);
      end
      n_checks++;
      if (q0.size() !== 0) begin
         n_fail++;
         $display("FAIL queue0_left: got %0d, want 0", q0.size());
      end
   endtask

   task automatic test_div4();
      pend_v[1] = 1'b0;
      watch1 = 1'b1;
      repeat (10) drive_period(1, 1, 1);
      repeat (2) drive_period(1, 2, 2);
      watch1 = 1'b0;
      n_checks++;
      if (lock_hits1 !== 0 || locked1 !== 1'b0) begin
         n_fail++;
         $display("FAIL div2_on_div4_lock: got %0d, want 0", lock_hits1);
      end
      n_checks++;
      if (errs1 !== 10 || ec1 !== 8'd10) begin
         n_fail++;
         $display("FAIL div2_on_div4_err: got %0d/%0d, want 10/10", errs1, ec1);
      end
      repeat (2) drive_period(1, 2, 2);
      n_checks++;
      if (locked1 !== 1'b0) begin
         n_fail++;
         $display("FAIL div4_early_lock: got %b, want 0", locked1);
      end
      drive_period(1, 2, 2);
      n_checks++;
      if (locked1 !== 1'b1) begin
         n_fail++;
         $display("FAIL div4_lock: got %b, want 1", locked1);
      end
      n_checks++;
      if (hl1 !== 8'd2 || ll1 !== 8'd2) begin
         n_fail++;
         $display("FAIL div4_len: got %0d/%0d, want 2/2", hl1, ll1);
      end
      drive_period(1, 2, 2);
      n_checks++;
      if (q1.size() !== 0 || errs1 !== 10) begin
         n_fail++;
         $display("FAIL div4_tail: got q=%0d errs=%0d, want 0/10", q1.size(), errs1);
      end
   endtask

   initial begin
      test_reset();
      test_div2_lock("div2");
      n_checks++;
      if (ec0 !== 8'd0) begin
         n_fail++;
         $display("FAIL div2_err_cnt: got %0d, want 0", ec0);
      end
      test_stretch();
      test_clear();
      test_stuck();
      test_reset_mid_lock();
      test_clr_coincident();
      test_saturate();
      test_div4();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
